// File: rtl/audio_pwm_out_if.sv
// Sample ingress bundle between the divider and the PWM output stage.
// Latency: none, pure wiring.
// Backpressure: din_ready from the sink gates acceptance of din/din_valid.
interface audio_pwm_out_if #(
    parameter int SAMPLE_W = 16
);
    logic [SAMPLE_W-1:0] din;
    logic                din_valid;
    logic                din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/audio_pwm_out.sv
// Generic synchronous FIFO, power-of-two depth, with occupancy count.
// Latency: a pushed word is at the head one cycle later; rdat_o shows the head combinationally.
// Backpressure: none internally; the caller must not push when full nor pop when empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdat_i,
    output logic [W-1:0]           rdat_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   COUNT_ONE = 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    // Pointer and occupancy next state; pointers wrap by natural overflow of AW bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards everything buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale words are never visible once count is cleared.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdat_i;
    end

    assign rdat_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// Buffers normalised samples, releases one per sample_tick and renders its MSBs as PWM.
// Latency: a popped sample drives pwm_out from the period after the next counter wrap, +1 register.
// Backpressure: din_ready low while the FIFO is full; a tick on an empty FIFO pulses underrun.
module audio_pwm_out #(
    parameter int SAMPLE_W = 16,
    parameter int PWM_BITS = 8,
    parameter int DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    audio_pwm_out_if.slave         in_if,
    input  logic                   sample_tick,
    output logic                   pwm_out,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
    localparam logic [PWM_BITS-1:0] CNT_ONE = 1;

    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic [PWM_BITS-1:0] head_duty;
    logic                unused_lsbs;

    logic [PWM_BITS-1:0] duty_pending_q, duty_pending_d;
    logic [PWM_BITS-1:0] duty_active_q, duty_active_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                pwm_out_q, pwm_out_d;
    logic                underrun_q, underrun_d;

    // Only the PWM-resolution MSBs are ever rendered, so only those are buffered.
    assign unused_lsbs = ^in_if.din[SAMPLE_W-PWM_BITS-1:0];

    // Count never exceeds DEPTH (a power of two), so its MSB alone marks full.
    assign fifo_full       = fifo_count[AW];
    assign fifo_empty      = (fifo_count == '0);
    assign in_if.din_ready = !fifo_full;
    assign push            = in_if.din_valid && !fifo_full;
    assign pop             = sample_tick && !fifo_empty;

    sync_fifo #(
        .W     (PWM_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdat_i  (in_if.din[SAMPLE_W-1 -: PWM_BITS]),
        .rdat_o  (head_duty),
        .count_o (fifo_count)
    );

    // Sample-rate release: pop loads the pending duty, an empty tick flags underrun.
    always_comb begin
        duty_pending_d = pop ? head_duty : duty_pending_q;
        underrun_d     = sample_tick && fifo_empty;
    end

    // PWM engine: free-running counter, duty swapped only at wrap, registered compare.
    always_comb begin
        pwm_cnt_d     = pwm_cnt_q + CNT_ONE;
        duty_active_d = (pwm_cnt_q == CNT_MAX) ? duty_pending_q : duty_active_q;
        pwm_out_d     = (pwm_cnt_q < duty_active_q);
    end

    // State registers for duty, counter and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_pending_q <= '0;
            duty_active_q  <= '0;
            pwm_cnt_q      <= '0;
            pwm_out_q      <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            duty_pending_q <= duty_pending_d;
            duty_active_q  <= duty_active_d;
            pwm_cnt_q      <= pwm_cnt_d;
            pwm_out_q      <= pwm_out_d;
            underrun_q     <= underrun_d;
        end
    end

    assign pwm_out  = pwm_out_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out: FIFO handshake, tick release, PWM duty and reset.
// Latency: expectations are indexed by posedges since the last reset release (cyc).
// Backpressure: exercised by holding din_valid against a full FIFO.
module tb_audio_pwm_out;
    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       pwm_out;
    logic       underrun;
    logic [2:0] fifo_count;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    int hi_acc = 0;

    audio_pwm_out_if #(.SAMPLE_W(16)) bus ();

    audio_pwm_out #(
        .SAMPLE_W (16),
        .PWM_BITS (8),
        .DEPTH    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_if       (bus),
        .sample_tick (sample_tick),
        .pwm_out     (pwm_out),
        .underrun    (underrun),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One posedge passes; outputs are sampled on the following negedge.
    task automatic next();
        @(negedge clk);
        cyc++;
        hi_acc += int'(pwm_out);
    endtask

    task automatic goto(input int t);
        while (cyc < t) next();
    endtask

    initial begin
        reset       = 1'b1;
        sample_tick = 1'b0;
        bus.din       = 16'h0000;
        bus.din_valid = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_count", fifo_count, 0);
        check("rst_ready", bus.din_ready, 1);
        check("rst_pwm", pwm_out, 0);
        check("rst_underrun", underrun, 0);

        // Push and tick while held in reset are ignored
        bus.din = 16'hFFFF; bus.din_valid = 1'b1; sample_tick = 1'b1;
        @(negedge clk);
        check("rst_ign_count", fifo_count, 0);
        check("rst_ign_underrun", underrun, 0);
        bus.din_valid = 1'b0; sample_tick = 1'b0; reset = 1'b0;
        cyc = 0; hi_acc = 0;

        // Tick on empty FIFO: one-cycle underrun
        sample_tick = 1'b1; next(); sample_tick = 1'b0;
        check("und_pulse", underrun, 1);
        check("und_count", fifo_count, 0);
        next();
        check("und_clear", underrun, 0);
        check("und_pwm", pwm_out, 0);

        // Push 0x8000, tick once: 128 of 256 high from next wrap
        bus.din = 16'h8000; bus.din_valid = 1'b1; next(); bus.din_valid = 1'b0;
        check("p80_count1", fifo_count, 1);
        sample_tick = 1'b1; next(); sample_tick = 1'b0;
        check("p80_count0", fifo_count, 0);
        check("p80_no_und", underrun, 0);
        goto(256);
        check("p80_pre_wrap_hi", hi_acc, 0);
        hi_acc = 0;
        goto(512);
        check("p80_hi", hi_acc, 128);
        hi_acc = 0;

        // Fill to four, fifth held off by backpressure
        bus.din_valid = 1'b1;
        bus.din = 16'hFF00; next();
        bus.din = 16'h0000; next();
        bus.din = 16'h4000; next();
        bus.din = 16'hC000; next();
        check("full_count", fifo_count, 4);
        check("full_ready", bus.din_ready, 0);
        bus.din = 16'h2000;
        goto(560);
        check("held_count", fifo_count, 4);
        check("held_ready", bus.din_ready, 0);
        // Tick with counter at 100: pops 0xFF00, fifth accepted next cycle
        goto(612);
        sample_tick = 1'b1; next(); sample_tick = 1'b0;
        check("pop_full_count", fifo_count, 3);
        check("pop_full_ready", bus.din_ready, 1);
        next();
        bus.din_valid = 1'b0;
        check("fifth_count", fifo_count, 4);
        goto(768);
        check("old_duty_hi", hi_acc, 128);
        hi_acc = 0;

        // Pop 0x0000 within the 255-duty period
        goto(799);
        sample_tick = 1'b1; next(); sample_tick = 1'b0;
        check("pop0_count", fifo_count, 3);
        goto(1024);
        check("duty255_hi", hi_acc, 255);
        hi_acc = 0;
        goto(1280);
        check("duty0_hi", hi_acc, 0);
        hi_acc = 0;

        // Count 2, then simultaneous push and tick
        goto(1289);
        sample_tick = 1'b1; next(); sample_tick = 1'b0;
        check("cnt2", fifo_count, 2);
        goto(1299);
        sample_tick = 1'b1; bus.din = 16'hF000; bus.din_valid = 1'b1;
        next();
        sample_tick = 1'b0; bus.din_valid = 1'b0;
        check("pushpop_count", fifo_count, 2);
        check("pushpop_no_und", underrun, 0);
        goto(1536);
        check("duty0_again_hi", hi_acc, 0);
        hi_acc = 0;
        goto(1792);
        check("dutyC0_hi", hi_acc, 192);
        goto(1799);
        sample_tick = 1'b1; next(); sample_tick = 1'b0;
        check("pop20_count", fifo_count, 1);
        goto(2048);
        hi_acc = 0;
        goto(2304);
        check("duty20_hi", hi_acc, 32);
        goto(2309);
        sample_tick = 1'b1; next(); sample_tick = 1'b0;
        check("popF0_count", fifo_count, 0);
        goto(2560);
        hi_acc = 0;
        goto(2816);
        check("dutyF0_hi", hi_acc, 240);

        // Buffer three, assert reset mid-period at counter 50
        bus.din_valid = 1'b1;
        bus.din = 16'h1234; next();
        bus.din = 16'h5678; next();
        bus.din = 16'h9ABC; next();
        bus.din_valid = 1'b0;
        check("buf3_count", fifo_count, 3);
        goto(2866);
        check("pre_rst_pwm", pwm_out, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_pwm", pwm_out, 0);
        check("arst_count", fifo_count, 0);
        check("arst_ready", bus.din_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0; hi_acc = 0;

        // Tick after release underruns; push+tick on empty completes the push
        sample_tick = 1'b1; next(); sample_tick = 1'b0;
        check("post_rst_und", underrun, 1);
        next();
        check("post_rst_und_clr", underrun, 0);
        bus.din = 16'h8000; bus.din_valid = 1'b1; sample_tick = 1'b1;
        next();
        bus.din_valid = 1'b0; sample_tick = 1'b0;
        check("pt_empty_und", underrun, 1);
        check("pt_empty_count", fifo_count, 1);
        goto(300);
        check("post_rst_pwm_quiet", hi_acc, 0);
        check("post_rst_count", fifo_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/audio_pwm_out.md
AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

Purpose: downstream stage of the voice-normalising divider. Buffers its 16-bit unsigned normalised sample, releases one sample per sample-rate tick and renders it as a PWM audio bit.

Interface
REQ-001 Parameter SAMPLE_W, default 16: width of the incoming sample.
REQ-002 Parameter PWM_BITS, default 8: PWM resolution, the duty source is sample[SAMPLE_W-1 -: PWM_BITS].
REQ-003 Parameter DEPTH, default 4: FIFO entries (power of two).
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port din  in  SAMPLE_W  normalised sample (divider dout), unsigned.
REQ-007 Port din_valid  in  1  din holds a sample to accept.
REQ-008 Port din_ready  out  1  FIFO can accept this cycle.
REQ-009 Port sample_tick  in  1  one-cycle pulse at audio sample rate.
REQ-010 Port pwm_out  out  1  registered PWM audio bit.
REQ-011 Port underrun  out  1  one-cycle pulse: tick arrived with FIFO empty.
REQ-012 Port fifo_count  out  log2(DEPTH)+1  current occupancy.

Function
REQ-013 din_ready SHALL be combinational: 1 when fifo_count < DEPTH, else 0.
REQ-014 A push SHALL occur on a rising edge with din_valid && din_ready; din is written at the tail.
REQ-015 When full, din_ready SHALL be 0 even if a pop occurs in the same cycle; the offered sample is not lost, only not accepted.
REQ-016 On a rising edge with sample_tick=1 and fifo_count>0, the head SHALL pop and its top PWM_BITS bits SHALL load duty_pending.
REQ-017 On sample_tick=1 with fifo_count=0, duty_pending SHALL hold and underrun SHALL be 1 for exactly the next cycle.
REQ-018 Simultaneous push and pop (not full, not empty): fifo_count SHALL be unchanged; pointers wrap modulo DEPTH.
REQ-019 Push and tick in the same cycle with FIFO empty: underrun SHALL pulse, the push SHALL complete, fifo_count becomes 1.
REQ-020 A PWM_BITS-bit counter pwm_cnt SHALL increment every cycle, wrapping 2^PWM_BITS-1 -> 0.
REQ-021 duty_active SHALL load from duty_pending only on the edge where pwm_cnt wraps to 0; no mid-period duty change.
REQ-022 pwm_out SHALL be registered as (pwm_cnt < duty_active), one-cycle latency from the counter value.
REQ-023 duty 0 SHALL give pwm_out constantly 0; duty 2^PWM_BITS-1 SHALL give 255 high cycles of 256 (PWM_BITS=8).
REQ-024 Latency: a sample popped at tick edge T affects pwm_out no earlier than the period that starts at the next wrap after T.

Reset
REQ-025 reset=1 SHALL asynchronously clear FIFO pointers, fifo_count=0, duty_pending=0, duty_active=0, pwm_cnt=0, pwm_out=0, underrun=0.
REQ-026 During reset din_ready SHALL read 1 (empty FIFO); pushes and ticks while reset=1 SHALL be ignored.
REQ-027 Reset asserted mid-period SHALL discard all buffered samples; after release pwm_cnt starts at 0 and pwm_out stays 0 until a sample pops and a wrap occurs.

Verification
REQ-028 Reset, then push 16'h8000 (din_valid 1 cycle), tick once -> fifo_count 1->0, from next wrap pwm_out high exactly 128 of every 256 cycles.
REQ-029 Push 4 samples without tick -> fifo_count=4, din_ready=0; fifth din_valid held -> not accepted until a tick pops, then accepted next cycle.
REQ-030 Tick with empty FIFO after reset -> underrun high one cycle, pwm_out stays 0, duty unchanged.
REQ-031 Push 16'hFF00 then 16'h0000, tick mid-period (pwm_cnt=100) -> current period keeps old duty; next period duty 255 (255 high/256), next tick+wrap gives pwm_out constant 0.
REQ-032 FIFO at count 2, push and tick same cycle -> count stays 2, order preserved (FIFO-ordered duties observed over following ticks).
REQ-033 Assert reset at pwm_cnt=50 with 3 samples buffered -> immediately pwm_out=0, fifo_count=0, din_ready=1; tick after release -> underrun pulse.
